// File: rtl/edi_store_sequencer.sv
// ---------------------------------------------------------------------------
// edi_store_sequencer
//
// String-store engine that consumes the EDI destination pointer. On start it
// captures EDI, the store word, the direction and the element count. It then
// writes the word to COUNT consecutive elements through a ready-handshake
// memory port. After every element it steps the pointer and writes it back to
// the EDI register over the shared register-write bus.
//
// Parameters:
//   STEP_BYTES     pointer step per element (1, 2 or 4)
//   WAIT_LIMIT     max cycles a write may wait for mem_ready before abort
//
// Ports:
//   clock_6        phase-6 clock, all state changes on its rising edge
//   reset          asynchronous, active-high
//   start          one-cycle request, only looked at while idle
//   count          number of elements to store (captured with start)
//   store_data     word written to every element (captured with start)
//   dir_down       0 = pointer counts up, 1 = pointer counts down
//   edi            current EDI register value (captured with start)
//   mem_addr       write address
//   mem_wdata      write data
//   mem_wr         write request, held until mem_ready accepts it
//   mem_ready      accepts the write at a rising edge while mem_wr=1
//   read_or_write  register-write select, 4'h6 = write EDI, 4'h0 = idle
//   write_data     new EDI value, valid while read_or_write = 4'h6
//   busy           high from the cycle after an accepted start until DONE
//   done           one-cycle completion pulse
//   error          one-cycle timeout pulse, always together with done
//   remaining      elements not yet stored
// ---------------------------------------------------------------------------
module edi_store_sequencer #(
  parameter int unsigned STEP_BYTES = 4,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clock_6,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] count,
  input  logic [31:0] store_data,
  input  logic        dir_down,
  input  logic [31:0] edi,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic        mem_ready,
  output logic [3:0]  read_or_write,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] remaining
);

  localparam logic [31:0] STEP      = 32'(STEP_BYTES);
  localparam logic [31:0] LIMIT     = 32'(WAIT_LIMIT);
  localparam logic [3:0]  RW_IDLE   = 4'h0;
  localparam logic [3:0]  RW_EDI    = 4'h6;

  // The abort path reuses S_UPDATE. The abort flag makes that single update
  // cycle write back the unstepped pointer and then finish with an error.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] ptr;
  logic [31:0] data;
  logic        dir;
  logic [31:0] wait_cnt;
  logic        abort;

  logic [31:0] ptr_stepped;
  logic [31:0] wait_next;

  // Next pointer value for an accepted element. Plain 32-bit arithmetic
  // gives the required wrap in both directions, for example 0xFFFF_FFFC + 4
  // gives 0x0 and 0x0 - 4 gives 0xFFFF_FFFC.
  assign ptr_stepped = dir ? (ptr - STEP) : (ptr + STEP);

  // Wait counter plus one. The abort is taken on the cycle that this value
  // reaches the limit. So mem_wr stays high for exactly WAIT_LIMIT cycles.
  assign wait_next = wait_cnt + 32'd1;

  // Sequencer. Every output is a register and is set on entry to the state
  // that shows it:
  //  - mem_wr rises on leaving ISSUE, so it is visible during WAIT.
  //  - read_or_write/write_data are set on leaving WAIT, so they are
  //    visible during UPDATE.
  //  - done/error are set on leaving UPDATE (or IDLE for count=0), so they
  //    are visible during DONE.
  // done, error and read_or_write default back to idle every cycle. This
  // makes them single-cycle pulses without extra clear logic.
  always_ff @(posedge clock_6 or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      data          <= '0;
      dir           <= 1'b0;
      wait_cnt      <= '0;
      abort         <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wr        <= 1'b0;
      read_or_write <= RW_IDLE;
      write_data    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      remaining     <= '0;
    end else begin
      done          <= 1'b0;
      error         <= 1'b0;
      read_or_write <= RW_IDLE;

      case (state)
        S_IDLE: begin
          if (start) begin
            ptr       <= edi;
            data      <= store_data;
            dir       <= dir_down;
            remaining <= count;
            abort     <= 1'b0;
            // An empty string finishes at once. It makes no memory write
            // and no EDI write, and busy never rises.
            if (count == 32'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ISSUE;
              busy  <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          mem_addr  <= ptr;
          mem_wdata <= data;
          mem_wr    <= 1'b1;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          // Address and data are not touched here. They stay stable for
          // the whole time the request is held.
          if (mem_ready) begin
            mem_wr        <= 1'b0;
            ptr           <= ptr_stepped;
            remaining     <= remaining - 32'd1;
            read_or_write <= RW_EDI;
            write_data    <= ptr_stepped;
            state         <= S_UPDATE;
          end else if (wait_next >= LIMIT) begin
            // Give up on this element. The pointer and remaining count
            // stay as they are, so EDI still names the unstored element.
            mem_wr        <= 1'b0;
            abort         <= 1'b1;
            wait_cnt      <= wait_next;
            read_or_write <= RW_EDI;
            write_data    <= ptr;
            state         <= S_UPDATE;
          end else begin
            wait_cnt <= wait_next;
          end
        end

        S_UPDATE: begin
          // EDI is written back after every element. This keeps the
          // architectural pointer current if a reset or abort arrives
          // part way through the string.
          if (abort || (remaining == 32'd0)) begin
            state <= S_DONE;
            done  <= 1'b1;
            error <= abort;
            busy  <= 1'b0;
          end else begin
            state <= S_ISSUE;
          end
        end

        S_DONE: begin
          // A start seen here is deliberately dropped. A new request is
          // accepted only once the engine is back in IDLE.
          abort <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/edi_store_sequencer.md
Name: edi_store_sequencer

Overview:
- String-store (STOS-style) engine and the consumer of the EDI destination pointer.
- Reads the current edi value as the destination address, issues COUNT memory writes of a 32-bit data word through a ready-handshake port, and steps the pointer up or down after each write.
- Writes the advanced pointer back into the EDI register over the shared register-write bus using code 4'h6 with data on write_data.
- Sits beside the register file in the execute stage, clocked on clock_6.

Parameters:
- STEP_BYTES, 4, pointer increment/decrement per element (1, 2 or 4).
- WAIT_LIMIT, 255, maximum clock_6 cycles mem_wr may wait for mem_ready before the operation aborts.

Ports:
- clock_6  input  1  phase-6 clock; all state updates on its posedge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- count  input  32  number of elements to store; sampled with start.
- store_data  input  32  word written to every element; sampled with start.
- dir_down  input  1  0 = pointer increments, 1 = pointer decrements; sampled with start.
- edi  input  32  current EDI register value; sampled with start.
- mem_addr  output  32  write address.
- mem_wdata  output  32  write data.
- mem_wr  output  1  write request; held until accepted.
- mem_ready  input  1  write accepted when high at a clock_6 posedge while mem_wr=1.
- read_or_write  output  4  register-write select; 4'h6 = write EDI, 4'h0 = idle.
- write_data  output  32  new EDI value; valid when read_or_write=4'h6.
- busy  output  1  high from the cycle after an accepted start until DONE.
- done  output  1  one-cycle completion pulse.
- error  output  1  one-cycle pulse on timeout abort, coincident with done.
- remaining  output  32  elements still to store.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. mem_addr, mem_wdata, write_data and remaining = 0. mem_wr, busy, done and error = 0. read_or_write = 4'h0. Wait counter = 0. Reset mid-operation abandons the transfer with no further mem or EDI write.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, UPDATE, DONE.
- IDLE:
  - On start=1, latch ptr=edi, data=store_data, dir=dir_down and remaining=count.
  - count=0: go to DONE with no memory write and no EDI write.
  - Otherwise go to ISSUE and set busy=1.
  - start while busy is ignored.
- ISSUE (1 cycle): mem_addr=ptr, mem_wdata=data, mem_wr=1, wait counter=0; go to WAIT.
- WAIT:
  - mem_wr stays 1. mem_addr and mem_wdata are stable.
  - mem_ready=1 at a posedge:
    - mem_wr=0.
    - ptr = ptr + STEP_BYTES (dir=0) or ptr - STEP_BYTES (dir=1), modulo 2^32; wrap 0xFFFF_FFFC+4 -> 0x0, 0x0-4 -> 0xFFFF_FFFC.
    - remaining = remaining - 1.
    - Go to UPDATE.
  - mem_ready=0: increment the wait counter.
  - Counter reaches WAIT_LIMIT: mem_wr=0, error=1 with done in DONE, no pointer step for the unaccepted element, go to UPDATE_ABORT. UPDATE_ABORT shares the UPDATE encoding: it writes back ptr as-is, then goes to DONE.
- UPDATE (exactly 1 cycle):
  - read_or_write=4'h6 and write_data=ptr; the EDI register captures this at the following clock_6 edge.
  - Next cycle read_or_write returns to 4'h0.
  - remaining=0: go to DONE. Otherwise go to ISSUE.
- Write-back happens after every element, so EDI is architecturally current if reset or an abort occurs.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start in the DONE cycle is ignored; start is accepted from IDLE only.
- Per-element throughput with mem_ready already high: ISSUE, WAIT and UPDATE = 3 cycles.
- Latency for count=N, zero wait: 1 (accept) + 3N + 1 (DONE).
- remaining is not decremented for an aborted element; it reports the unstored elements.

Test Plan:
- Reset then idle: after reset, read_or_write=4'h0, mem_wr=0, busy=0 and remaining=0. The EDI register holds 0x0000_0888.
- Ascending store:
  - Stimulus: edi=0x888, count=3, dir_down=0, store_data=0xDEAD_BEEF, mem_ready tied 1.
  - Memory writes: 0x888, 0x88C, 0x890.
  - read_or_write=6 pulses carry 0x88C, 0x890, 0x894.
  - done pulses one cycle after the third write-back; EDI ends at 0x894.
- Descending with wrap: edi=0x4, count=2, dir_down=1 -> writes to 0x4 then 0x0; write-backs 0x0 and 0xFFFF_FFFC.
- Zero count: count=0 -> done one cycle after accepting start; no mem_wr and no read_or_write=6 pulse.
- Back-pressure and timeout:
  - mem_ready low for 10 cycles: mem_wr, mem_addr and mem_wdata stay stable; the write completes on the first mem_ready=1.
  - mem_ready held low: after 255 wait cycles mem_wr drops; error and done pulse together; write-back equals the unstepped pointer; remaining is unchanged.
- Reset mid-transfer: count=5, assert reset during the second WAIT -> all outputs return to reset values immediately; a subsequent start with count=1 runs normally.
